pattern_serializer: RTL

Serial bit-stream transmitter feeding the pattern-detector datapath. Accepts a parallel word through a ready/load handshake and shifts it out MSB-first on a single serial line, one bit per clock. It is the producing end of the 1-bit serial interface that the Mealy pattern detectors consume, and it replaces hand-built shift sequences in benches and top levels.

---
 rtl/pattern_serializer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pattern_serializer.sv
// pattern_serializer: loads a parallel word through a ready/load handshake and
// shifts it out MSB-first, one bit per clock, onto the serial line `o`.
// Optional even-parity trailer bit: define PATTERN_SERIALIZER_PARITY_EN.
module pattern_serializer #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic             o,
    output logic             valid,
    output logic             done
);

    localparam int unsigned   CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
`ifdef PATTERN_SERIALIZER_PARITY_EN
        , PARITY = 2'd2
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             last_bit;

`ifdef PATTERN_SERIALIZER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign last_bit = (cnt_q == '0);

    // State, shift register and bit counter; reset discards any frame in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PATTERN_SERIALIZER_PARITY_EN
    // Even parity of the captured word, held for the trailer cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    // Next-state: advance the frame, then let an accepted load override it.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
`ifdef PATTERN_SERIALIZER_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            SHIFT: begin
                shift_d = shift_q << 1;
                if (last_bit) begin
                    cnt_d = '0;
`ifdef PATTERN_SERIALIZER_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`ifdef PATTERN_SERIALIZER_PARITY_EN
            PARITY: begin
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
        // ready is only high in IDLE or the final cycle of a frame, so this
        // override also gives gapless back-to-back frames.
        if (load && ready) begin
            state_d = SHIFT;
            shift_d = data;
            cnt_d   = CNT_LAST;
`ifdef PATTERN_SERIALIZER_PARITY_EN
            parity_d = ^data;
`endif
        end
    end

    // Outputs decoded from registered state and counter only.
    always_comb begin
        ready = 1'b0;
        o     = 1'b0;
        valid = 1'b0;
        done  = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
            end
            SHIFT: begin
                o     = shift_q[WIDTH-1];
                valid = 1'b1;
`ifndef PATTERN_SERIALIZER_PARITY_EN
                done  = last_bit;
                ready = last_bit;
`endif
            end
`ifdef PATTERN_SERIALIZER_PARITY_EN
            PARITY: begin
                o     = parity_q;
                valid = 1'b1;
                done  = 1'b1;
                ready = 1'b1;
            end
`endif
            default: begin
                ready = 1'b0;
            end
        endcase
    end

endmodule
